lsu: RTL

Multi-cycle load/store unit that sits directly downstream of the ALU and replaces the single-cycle data memory port. It takes an ALU-computed address, store data and memory-op code from the core, runs one valid/ready transaction on a 32-bit data bus, and returns a sign- or zero-extended load result or a store acknowledge. The core stalls while the unit is busy.

---
 rtl/npc_pkg.sv | 17 +
 rtl/lsu_fmt.sv | 51 +++++
 rtl/lsu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared memory-op codes and load/store unit state type
package npc_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_fmt.sv
// rtl/lsu_fmt.sv - store lane alignment, load extract/extend and alignment check
module lsu_fmt
    import npc_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  lane,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        op_ok,
    output logic        aligned
);

    logic [31:0] shifted;

    always_comb begin
        shifted = ld_word >> {lane, 3'b000};
        wstrb   = 4'b0000;
        wdata   = st_data;
        ld_data = 32'h0;
        op_ok   = 1'b1;
        aligned = 1'b1;
        case (memop)
            MEMOP_B, MEMOP_BU: begin
                wstrb   = 4'b0001 << lane;
                wdata   = {4{st_data[7:0]}};
                ld_data = (memop == MEMOP_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'h0, shifted[7:0]};
            end
            MEMOP_H, MEMOP_HU: begin
                wstrb   = 4'b0011 << lane;
                wdata   = {2{st_data[15:0]}};
                ld_data = (memop == MEMOP_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
                aligned = ~lane[0];
            end
            MEMOP_W: begin
                wstrb   = 4'b1111;
                ld_data = ld_word;
                aligned = (lane == 2'b00);
            end
            default: begin
                op_ok   = 1'b0;
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - multi-cycle load/store unit, one valid/ready bus transaction per request
module lsu
    import npc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [2:0]        MemOp,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              resp_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_wen,
    output logic [3:0]        bus_req_wstrb,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_rdata
);

    lsu_state_t        state;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] baddr_q;
    logic              bwen_q;
    logic [3:0]        bstrb_q;
    logic [DATA_W-1:0] bwdata_q;

    logic [2:0]  f_op;
    logic [1:0]  f_lane;
    logic [3:0]  f_wstrb;
    logic [31:0] f_wdata;
    logic [31:0] f_ld;
    logic        f_op_ok;
    logic        f_aligned;
    logic        idle;

    // The single formatter sees live request fields in IDLE and latched fields otherwise.
    assign idle   = (state == LSU_IDLE);
    assign f_op   = idle ? MemOp : op_q;
    assign f_lane = idle ? addr[1:0] : lane_q;

    lsu_fmt u_fmt (
        .memop   (f_op),
        .lane    (f_lane),
        .st_data (wdata),
        .ld_word (bus_resp_rdata),
        .wstrb   (f_wstrb),
        .wdata   (f_wdata),
        .ld_data (f_ld),
        .op_ok   (f_op_ok),
        .aligned (f_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LSU_IDLE;
            op_q     <= 3'b000;
            lane_q   <= 2'b00;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            baddr_q  <= '0;
            bwen_q   <= 1'b0;
            bstrb_q  <= 4'b0000;
            bwdata_q <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid && (MemRd ^ MemWr)) begin
                        op_q     <= MemOp;
                        lane_q   <= addr[1:0];
                        wr_q     <= MemWr;
                        baddr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        bwen_q   <= MemWr;
                        bstrb_q  <= MemWr ? f_wstrb : 4'b0000;
                        bwdata_q <= MemWr ? f_wdata : '0;
                        rdata_q  <= '0;
                        if (f_op_ok && f_aligned) begin
                            err_q <= 1'b0;
                            state <= LSU_REQ;
                        end else begin
                            err_q <= 1'b1;
                            state <= LSU_DONE;
                        end
                    end else if (req_valid && MemRd && MemWr) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= LSU_DONE;
                    end
                end
                LSU_REQ: begin
                    if (bus_req_ready) state <= LSU_WAIT;
                end
                LSU_WAIT: begin
                    if (bus_resp_valid) begin
                        rdata_q <= wr_q ? '0 : f_ld;
                        state   <= LSU_DONE;
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready     = idle;
    assign resp_valid    = (state == LSU_DONE);
    assign rdata         = rdata_q;
    assign resp_err      = err_q;
    assign bus_req_valid = (state == LSU_REQ);
    assign bus_req_addr  = baddr_q;
    assign bus_req_wen   = bwen_q;
    assign bus_req_wstrb = bstrb_q;
    assign bus_req_wdata = bwdata_q;

endmodule
